// File: rtl/ariane_pkg.sv
// Shared types for the EX-stage branch unit and its resolution queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ariane_pkg;

  // Resolution entries carry addresses at the widest supported VLEN;
  // narrower instances zero-extend into the upper bits.
  localparam int unsigned VLEN_MAX = 64;

  typedef enum logic [1:0] {
    CF_BRANCH = 2'd0,
    CF_JUMP   = 2'd1,
    CF_JALR   = 2'd2,
    CF_RETURN = 2'd3
  } cf_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } bu_state_e;

  typedef struct packed {
    logic [VLEN_MAX-1:0] pc;
    logic [VLEN_MAX-1:0] target;
    logic                taken;
    logic                mispredict;
    logic                clear;
    cf_t                 cf_type;
  } resolve_entry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// Circular queue of branch resolutions between EX and the frontend.
// Latency: an entry pushed at cycle N is visible at the head in cycle N+1.
// Backpressure: full_o while DEPTH entries are held; pushes while full are ignored.
module branch_resolve_queue
  import ariane_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  resolve_entry_t data_i,
  input  logic           pop_i,
  output resolve_entry_t data_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [CW-1:0]  count_o
);

  resolve_entry_t mem_q [DEPTH];
  resolve_entry_t mem_d [DEPTH];
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next storage, pointers and occupancy; simultaneous push+pop keeps the count.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = ptr_next(wr_q);
    end
    if (do_pop) begin
      rd_d = ptr_next(rd_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue state registers; reset is the only way to discard entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_unit_pipe.sv
// EX branch unit: target/link computation, prediction check, resolution enqueue, wrong-path squash.
// Latency: link/exception combinational; resolution at queue head and mispredict pulse one cycle after issue.
// Backpressure: branch_ready_o drops while the resolution queue is full. Optional: BRANCH_UNIT_PERF_EN.
module branch_unit_pipe
  import ariane_pkg::*;
#(
  parameter int unsigned VLEN          = 64,
  parameter int unsigned RESOLVE_DEPTH = 2,
  parameter bit          RVC           = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            fu_valid_i,
  input  logic            branch_valid_i,
  output logic            branch_ready_o,
  input  logic            is_jalr_i,
  input  logic [VLEN-1:0] operand_a_i,
  input  logic [VLEN-1:0] imm_i,
  input  logic [VLEN-1:0] pc_i,
  input  logic            is_compressed_i,
  input  logic            branch_comp_res_i,
  input  logic            predict_valid_i,
  input  logic            predict_taken_i,
  input  logic [VLEN-1:0] predict_address_i,
  input  cf_t             cf_type_i,
  output logic [VLEN-1:0] branch_result_o,
  output logic            resolved_valid_o,
  input  logic            resolved_ready_i,
  output resolve_entry_t  resolved_o,
  output logic            mispredict_o,
  output logic            ex_valid_o,
  output logic [VLEN-1:0] ex_tval_o,
  output logic [31:0]     perf_branch_o,
  output logic [31:0]     perf_misp_o
);

  localparam int unsigned CW = $clog2(RESOLVE_DEPTH + 1);

  bu_state_e       state_q, state_d;
  logic            mispredict_q, mispredict_d;
  logic [VLEN-1:0] next_pc, jump_base, jump_target, res_target, entry_pc;
  logic            branch_misp, misaligned;
  logic            br_enq, nb_enq, enq, enq_misp;
  logic            q_full, q_empty;
  logic [CW-1:0]   q_count;
  resolve_entry_t  q_din;

  // Address arithmetic and prediction check for the instruction in EX.
  always_comb begin
    next_pc     = pc_i + (is_compressed_i ? VLEN'(2) : VLEN'(4));
    jump_base   = is_jalr_i ? operand_a_i : pc_i;
    jump_target = jump_base + imm_i;
    if (is_jalr_i) jump_target[0] = 1'b0;
    res_target  = branch_comp_res_i ? jump_target : next_pc;
    // A 32-bit instruction sitting on a half-word boundary reports the following word.
    entry_pc    = (is_compressed_i || !pc_i[1]) ? pc_i : ({pc_i[VLEN-1:2], 2'b00} + VLEN'(4));
    if (predict_valid_i) begin
      branch_misp = (branch_comp_res_i != predict_taken_i) ||
                    (branch_comp_res_i && (predict_address_i != jump_target));
    end else begin
      branch_misp = branch_comp_res_i;
    end
    misaligned  = RVC ? res_target[0] : (res_target[1:0] != 2'b00);
  end

  // RUN/SQUASH next state, enqueue decisions and misaligned-target exception.
  always_comb begin
    state_d    = state_q;
    br_enq     = 1'b0;
    nb_enq     = 1'b0;
    ex_valid_o = 1'b0;
    ex_tval_o  = '0;
    case (state_q)
      RUN: begin
        // A flush in the same cycle marks the issue as wrong-path.
        if (!flush_i) begin
          if (branch_valid_i) begin
            if (misaligned) begin
              ex_valid_o = 1'b1;
              ex_tval_o  = pc_i;
            end else if (!q_full) begin
              br_enq = 1'b1;
            end
          end else if (fu_valid_i && predict_valid_i && predict_taken_i && !q_full) begin
            nb_enq = 1'b1;
          end
        end
      end
      SQUASH: begin
        if (flush_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    enq      = br_enq || nb_enq;
    enq_misp = nb_enq || (br_enq && branch_misp);
    if (enq_misp) state_d = SQUASH;
    mispredict_d = enq_misp;
  end

  // Resolution record; a non-branch predicted taken redirects to its own fall-through.
  always_comb begin
    q_din            = '0;
    q_din.pc         = VLEN_MAX'(entry_pc);
    q_din.target     = nb_enq ? VLEN_MAX'(next_pc) : VLEN_MAX'(res_target);
    q_din.taken      = nb_enq ? 1'b0 : branch_comp_res_i;
    q_din.mispredict = nb_enq || branch_misp;
    q_din.clear      = nb_enq;
    q_din.cf_type    = cf_type_i;
  end

  // FSM state and the one-cycle mispredict pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mispredict_q <= mispredict_d;
    end
  end

  branch_resolve_queue #(.DEPTH(RESOLVE_DEPTH)) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (enq),
    .data_i  (q_din),
    .pop_i   (resolved_ready_i),
    .data_o  (resolved_o),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign branch_ready_o   = !q_full;
  assign branch_result_o  = next_pc;
  assign resolved_valid_o = !q_empty;
  assign mispredict_o     = mispredict_q;

`ifdef BRANCH_UNIT_PERF_EN
  logic [31:0] perf_branch_q, perf_branch_d, perf_misp_q, perf_misp_d;

  // Free-running event counters, wrapping at 2^32.
  always_comb begin
    perf_branch_d = perf_branch_q + {31'd0, br_enq};
    perf_misp_d   = perf_misp_q + {31'd0, enq_misp};
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_branch_q <= '0;
      perf_misp_q   <= '0;
    end else begin
      perf_branch_q <= perf_branch_d;
      perf_misp_q   <= perf_misp_d;
    end
  end

  assign perf_branch_o = perf_branch_q;
  assign perf_misp_o   = perf_misp_q;
`else
  assign perf_branch_o = '0;
  assign perf_misp_o   = '0;
`endif

  // Issuing into a full queue would lose a resolution.
  a_no_issue_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                         !(branch_valid_i && q_full));
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  q_count <= CW'(RESOLVE_DEPTH));

endmodule

// File: tb/tb_branch_unit_pipe.sv
module tb_branch_unit_pipe;
  import ariane_pkg::*;

`ifdef BRANCH_UNIT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        flush, fu_valid, branch_valid, is_jalr, is_c, cmp, pv, pt, rdy;
  logic [63:0] opa, imm, pc, pa;
  cf_t         cf;

  logic           brdy, rvalid, misp_o, exv;
  logic [63:0]    link, tval;
  resolve_entry_t res;
  logic [31:0]    perf_b, perf_m;

  logic           brdy0, rvalid0, misp0, exv0;
  logic [63:0]    link0, tval0;
  resolve_entry_t res0;
  logic [31:0]    perf_b0, perf_m0;

  branch_unit_pipe #(.VLEN(64), .RESOLVE_DEPTH(2), .RVC(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fu_valid_i(fu_valid),
    .branch_valid_i(branch_valid), .branch_ready_o(brdy), .is_jalr_i(is_jalr),
    .operand_a_i(opa), .imm_i(imm), .pc_i(pc), .is_compressed_i(is_c),
    .branch_comp_res_i(cmp), .predict_valid_i(pv), .predict_taken_i(pt),
    .predict_address_i(pa), .cf_type_i(cf), .branch_result_o(link),
    .resolved_valid_o(rvalid), .resolved_ready_i(rdy), .resolved_o(res),
    .mispredict_o(misp_o), .ex_valid_o(exv), .ex_tval_o(tval),
    .perf_branch_o(perf_b), .perf_misp_o(perf_m)
  );

  // 4-byte-alignment instance; its queue is always drained.
  branch_unit_pipe #(.VLEN(64), .RESOLVE_DEPTH(2), .RVC(1'b0)) dut_rvc0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fu_valid_i(fu_valid),
    .branch_valid_i(branch_valid), .branch_ready_o(brdy0), .is_jalr_i(is_jalr),
    .operand_a_i(opa), .imm_i(imm), .pc_i(pc), .is_compressed_i(is_c),
    .branch_comp_res_i(cmp), .predict_valid_i(pv), .predict_taken_i(pt),
    .predict_address_i(pa), .cf_type_i(cf), .branch_result_o(link0),
    .resolved_valid_o(rvalid0), .resolved_ready_i(1'b1), .resolved_o(res0),
    .mispredict_o(misp0), .ex_valid_o(exv0), .ex_tval_o(tval0),
    .perf_branch_o(perf_b0), .perf_misp_o(perf_m0)
  );

  typedef struct {
    logic        bv, fu, jalr, c, cmp, pv, pt, fl, rdy;
    logic [63:0] opa, imm, pc, pa;
    logic        enq, ex, ex0, tkn, msp, clr, brdy;
    logic [63:0] link, tgt, epc;
  } vec_t;

  vec_t           tbl[$];
  resolve_entry_t sb[$];
  int             checks = 0;
  int             fails  = 0;
  logic           exp_pulse = 1'b0;

  function automatic vec_t mk(input logic bv, fu, jalr, c, cmp, pv, pt, fl,
                              input logic [63:0] opa_v, imm_v, pc_v, pa_v,
                              input logic enq, ex, ex0, tkn, msp, clr,
                              input logic [63:0] link_v, tgt, epc);
    vec_t v;
    v.bv = bv; v.fu = fu; v.jalr = jalr; v.c = c; v.cmp = cmp; v.pv = pv; v.pt = pt; v.fl = fl;
    v.rdy = 1'b1; v.brdy = 1'b1;
    v.opa = opa_v; v.imm = imm_v; v.pc = pc_v; v.pa = pa_v;
    v.enq = enq; v.ex = ex; v.ex0 = ex0; v.tkn = tkn; v.msp = msp; v.clr = clr;
    v.link = link_v; v.tgt = tgt; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One issue cycle: check last cycle's pulse, drive, check comb outputs, record expectation.
  task automatic run_vec(input vec_t v, input string tag);
    resolve_entry_t e;
    @(negedge clk);
    chk({tag, "_misp_pulse"}, misp_o, exp_pulse);
    #1;
    branch_valid = v.bv; fu_valid = v.fu; is_jalr = v.jalr; is_c = v.c; cmp = v.cmp;
    pv = v.pv; pt = v.pt; flush = v.fl; rdy = v.rdy;
    opa = v.opa; imm = v.imm; pc = v.pc; pa = v.pa;
    cf = v.jalr ? CF_JALR : CF_BRANCH;
    #1;
    chk({tag, "_link"}, link, v.link);
    chk({tag, "_ex_valid"}, exv, v.ex);
    chk({tag, "_ex_valid_rvc0"}, exv0, v.ex0);
    chk({tag, "_branch_ready"}, brdy, v.brdy);
    if (v.ex)  chk({tag, "_ex_tval"}, tval, v.pc);
    if (v.ex0) chk({tag, "_ex_tval_rvc0"}, tval0, v.pc);
    if (v.enq) begin
      e.pc = v.epc; e.target = v.tgt; e.taken = v.tkn; e.mispredict = v.msp;
      e.clear = v.clr; e.cf_type = v.jalr ? CF_JALR : CF_BRANCH;
      sb.push_back(e);
    end
    exp_pulse = v.enq && v.msp;
  endtask

  // Scoreboard: compare the queue head whenever the frontend consumes it.
  initial begin
    resolve_entry_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && rvalid && rdy) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL sb_unexpected: got entry pc 0x%0h, expected no entry", res.pc);
        end else begin
          e = sb.pop_front();
          chk("entry_pc", res.pc, e.pc);
          chk("entry_target", res.target, e.target);
          chk("entry_taken", res.taken, e.taken);
          chk("entry_misp", res.mispredict, e.mispredict);
          chk("entry_clear", res.clear, e.clear);
          chk("entry_cf", res.cf_type, e.cf_type);
        end
      end
    end
  end

  initial begin
    vec_t v;
    flush = 0; fu_valid = 0; branch_valid = 0; is_jalr = 0; is_c = 0; cmp = 0;
    pv = 0; pt = 0; rdy = 1; opa = 0; imm = 0; pc = 0; pa = 0; cf = CF_BRANCH;

    //            bv fu jr c cmp pv pt fl  opa      imm    pc       pa        enq ex ex0 tk ms cl  link     tgt      epc
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 64'h0,    64'h20, 64'h1000, 64'h1020, 1, 0, 0, 1, 0, 0, 64'h1004, 64'h1020, 64'h1000));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 64'h0,    64'h40, 64'h1100, 64'h0,    1, 0, 0, 0, 0, 0, 64'h1104, 64'h1104, 64'h1100));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 64'h0,    64'h10, 64'h1200, 64'h1300, 1, 0, 0, 1, 1, 0, 64'h1204, 64'h1210, 64'h1200));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 64'h0,    64'h1,  64'h1400, 64'h0,    0, 0, 0, 0, 0, 0, 64'h1404, 64'h0,    64'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h0,  64'h0,    64'h0,    0, 0, 0, 0, 0, 0, 64'h4,    64'h0,    64'h0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 64'h0,    64'h10, 64'h1502, 64'h0,    1, 0, 0, 0, 0, 0, 64'h1504, 64'h1504, 64'h1502));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 64'h0,    64'h0,  64'h1602, 64'h0,    1, 0, 1, 0, 0, 0, 64'h1606, 64'h1606, 64'h1604));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 1, 64'h2003, 64'h0,  64'h1700, 64'h0,    0, 0, 0, 0, 0, 0, 64'h1704, 64'h0,    64'h0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 64'h2003, 64'h0,  64'h1700, 64'h0,    1, 0, 1, 1, 1, 0, 64'h1704, 64'h2002, 64'h1700));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 64'h0,    64'h8,  64'h1800, 64'h0,    0, 0, 0, 0, 0, 0, 64'h1804, 64'h0,    64'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h0,  64'h0,    64'h0,    0, 0, 0, 0, 0, 0, 64'h4,    64'h0,    64'h0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 64'h0,    64'h0,  64'h3000, 64'h0,    1, 0, 0, 0, 1, 1, 64'h3002, 64'h3002, 64'h3000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h0,  64'h0,    64'h0,    0, 0, 0, 0, 0, 0, 64'h4,    64'h0,    64'h0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 64'h0,    64'h5,  64'h5000, 64'h0,    0, 1, 1, 0, 0, 0, 64'h5004, 64'h0,    64'h0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 64'h0,    64'h2,  64'h4000, 64'h0,    1, 0, 1, 1, 1, 0, 64'h4004, 64'h4002, 64'h4000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h0,    64'h0,  64'h0,    64'h0,    0, 0, 0, 0, 0, 0, 64'h4,    64'h0,    64'h0));

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_resolved_valid", rvalid, 1'b0);
    chk("rst_mispredict", misp_o, 1'b0);
    chk("rst_branch_ready", brdy, 1'b1);
    chk("rst_perf_branch", perf_b, 64'd0);
    chk("rst_perf_misp", perf_m, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // Queue fill with frontend stalled, then pop-only and push+pop cycles.
    v = mk(1, 0, 0, 0, 1, 1, 1, 0, 64'h0, 64'h10, 64'h6000, 64'h6010, 1, 0, 0, 1, 0, 0, 64'h6004, 64'h6010, 64'h6000);
    v.rdy = 0; run_vec(v, "q_b1");
    v = mk(1, 0, 0, 0, 1, 1, 1, 0, 64'h0, 64'h10, 64'h6100, 64'h6110, 1, 0, 0, 1, 0, 0, 64'h6104, 64'h6110, 64'h6100);
    v.rdy = 0; run_vec(v, "q_b2");
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 64'h4, 64'h0, 64'h0);
    v.brdy = 0; run_vec(v, "q_full_pop");
    v = mk(1, 0, 0, 0, 0, 1, 0, 0, 64'h0, 64'h10, 64'h6200, 64'h0, 1, 0, 0, 0, 0, 0, 64'h6204, 64'h6204, 64'h6200);
    run_vec(v, "q_push_pop");
    v = mk(1, 0, 0, 0, 0, 1, 0, 0, 64'h0, 64'h10, 64'h6300, 64'h0, 1, 0, 0, 0, 0, 0, 64'h6304, 64'h6304, 64'h6300);
    v.rdy = 0; run_vec(v, "q_b4");
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 64'h4, 64'h0, 64'h0);
    v.rdy = 0; v.brdy = 0; run_vec(v, "q_full_hold");
    chk("perf_branch_pre_reset", perf_b, PERF ? 64'd11 : 64'd0);
    chk("perf_misp_pre_reset", perf_m, PERF ? 64'd4 : 64'd0);

    // Reset with two entries queued empties the queue immediately.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resolved_valid", rvalid, 1'b0);
    chk("mid_rst_branch_ready", brdy, 1'b1);
    chk("mid_rst_mispredict", misp_o, 1'b0);
    sb.delete();
    exp_pulse = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_perf_branch", perf_b, 64'd0);
    rst_n = 1'b1;

    // Three branches, one of them mispredicted.
    v = mk(1, 0, 0, 0, 1, 1, 1, 0, 64'h0, 64'h10, 64'h7000, 64'h7010, 1, 0, 0, 1, 0, 0, 64'h7004, 64'h7010, 64'h7000);
    run_vec(v, "p1");
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h10, 64'h7100, 64'h0, 1, 0, 0, 0, 0, 0, 64'h7104, 64'h7104, 64'h7100);
    run_vec(v, "p2");
    v = mk(1, 0, 0, 0, 1, 0, 0, 0, 64'h0, 64'h10, 64'h7200, 64'h0, 1, 0, 0, 1, 1, 0, 64'h7204, 64'h7210, 64'h7200);
    run_vec(v, "p3");
    v = mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 64'h4, 64'h0, 64'h0);
    run_vec(v, "p_flush");
    chk("perf_branch", perf_b, PERF ? 64'd3 : 64'd0);
    chk("perf_misp", perf_m, PERF ? 64'd1 : 64'd0);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 64'h4, 64'h0, 64'h0);
    run_vec(v, "idle");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #4;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
